// File: rtl/maze_pkg.sv
// Shared definitions for the maze game: grid size, player FSM states,
// step directions and the tile-addressing helper.
package maze_pkg;

    localparam int MAZE_DIM = 16;
    localparam logic [9:0] MOVE_COUNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_CHECK = 2'd2,
        ST_WON   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    // Bit position of tile (x, y) in path_data: x + 16*y.
    function automatic logic [7:0] tile_index(input logic [3:0] x, input logic [3:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/maze_btn_debounce.sv
// One push button: 2-flop synchronizer, stability counter, debounced level
// and a single-cycle pulse on each debounced rising edge.
module maze_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             level_d_r;
    logic             pulse_r;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Adopt the synchronized level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
        end else if (sync2_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r   <= CNT_ZERO;
                level_r <= sync2_r;
            end else begin
                cnt_r   <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= CNT_ZERO;
        end
    end

    // Register a one-cycle request on the debounced rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_d_r <= 1'b0;
            pulse_r   <= 1'b0;
        end else begin
            level_d_r <= level_r;
            pulse_r   <= level_r & ~level_d_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/maze_player_ctrl.sv
// Player-movement controller: debounced direction requests move the
// character one tile at a time through the maze, rejecting walls and
// off-maze steps, counting legal moves and flagging arrival at the finish.
module maze_player_ctrl
    import maze_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic [255:0] path_data,
    input  logic [4:0]   maze_width,
    input  logic [4:0]   maze_height,
    input  logic [4:0]   start_x,
    input  logic [4:0]   start_y,
    input  logic [4:0]   finish_x,
    input  logic [4:0]   finish_y,
    output logic [6:0]   char_x,
    output logic [6:0]   char_y,
    output logic [9:0]   move_count,
    output logic         won,
    output logic         playing
);

    logic       pulse_up_s;
    logic       pulse_down_s;
    logic       pulse_left_s;
    logic       pulse_right_s;
    dir_e       req_dir_s;

    state_e     state_r;
    state_e     state_nxt_s;
    dir_e       dir_r;
    dir_e       dir_nxt_s;
    logic [5:0] tx_r;
    logic [5:0] ty_r;
    logic [5:0] tx_nxt_s;
    logic [5:0] ty_nxt_s;
    logic [5:0] req_tx_s;
    logic [5:0] req_ty_s;
    logic [4:0] char_x_r;
    logic [4:0] char_y_r;
    logic [4:0] char_x_nxt_s;
    logic [4:0] char_y_nxt_s;
    logic [9:0] count_r;
    logic [9:0] count_nxt_s;
    logic       won_r;
    logic       playing_r;

    logic       underflow_s;
    logic       in_range_s;
    logic       open_s;
    logic       legal_s;
    logic       at_finish_s;

    maze_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .reset(reset), .btn(btn_up), .pulse(pulse_up_s)
    );
    maze_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .reset(reset), .btn(btn_down), .pulse(pulse_down_s)
    );
    maze_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk(clk), .reset(reset), .btn(btn_left), .pulse(pulse_left_s)
    );
    maze_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk(clk), .reset(reset), .btn(btn_right), .pulse(pulse_right_s)
    );

    // Pick one request per cycle (up > down > left > right) and compute its target tile.
    always_comb begin
        req_dir_s = DIR_NONE;
        req_tx_s  = {1'b0, char_x_r};
        req_ty_s  = {1'b0, char_y_r};
        if (pulse_up_s) begin
            req_dir_s = DIR_UP;
            req_ty_s  = {1'b0, char_y_r} - 6'd1;
        end else if (pulse_down_s) begin
            req_dir_s = DIR_DOWN;
            req_ty_s  = {1'b0, char_y_r} + 6'd1;
        end else if (pulse_left_s) begin
            req_dir_s = DIR_LEFT;
            req_tx_s  = {1'b0, char_x_r} - 6'd1;
        end else if (pulse_right_s) begin
            req_dir_s = DIR_RIGHT;
            req_tx_s  = {1'b0, char_x_r} + 6'd1;
        end else begin
            req_dir_s = DIR_NONE;
        end
    end

    // Judge the latched move against the live maze description.
    always_comb begin
        underflow_s = ((dir_r == DIR_LEFT) && (char_x_r == 5'd0)) ||
                      ((dir_r == DIR_UP)   && (char_y_r == 5'd0));
        in_range_s  = (tx_r < {1'b0, maze_width})  && (ty_r < {1'b0, maze_height}) &&
                      (tx_r < 6'(MAZE_DIM))        && (ty_r < 6'(MAZE_DIM));
        open_s      = path_data[tile_index(tx_r[3:0], ty_r[3:0])];
        legal_s     = !underflow_s && in_range_s && open_s;
        at_finish_s = (tx_r == {1'b0, finish_x}) && (ty_r == {1'b0, finish_y});
    end

    // Next-state, latched move and position/counter updates; load overrides everything.
    always_comb begin
        state_nxt_s  = state_r;
        dir_nxt_s    = dir_r;
        tx_nxt_s     = tx_r;
        ty_nxt_s     = ty_r;
        char_x_nxt_s = char_x_r;
        char_y_nxt_s = char_y_r;
        count_nxt_s  = count_r;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_IDLE;
            end
            ST_PLAY: begin
                if (req_dir_s != DIR_NONE) begin
                    dir_nxt_s   = req_dir_s;
                    tx_nxt_s    = req_tx_s;
                    ty_nxt_s    = req_ty_s;
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            ST_CHECK: begin
                dir_nxt_s = DIR_NONE;
                if (legal_s) begin
                    char_x_nxt_s = tx_r[4:0];
                    char_y_nxt_s = ty_r[4:0];
                    if (count_r == MOVE_COUNT_MAX) begin
                        count_nxt_s = count_r;
                    end else begin
                        count_nxt_s = count_r + 10'd1;
                    end
                    if (at_finish_s) begin
                        state_nxt_s = ST_WON;
                    end else begin
                        state_nxt_s = ST_PLAY;
                    end
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            ST_WON: begin
                state_nxt_s = ST_WON;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (load) begin
            state_nxt_s  = ST_PLAY;
            dir_nxt_s    = DIR_NONE;
            char_x_nxt_s = start_x;
            char_y_nxt_s = start_y;
            count_nxt_s  = 10'd0;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State, latched move and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            dir_r     <= DIR_NONE;
            tx_r      <= 6'd0;
            ty_r      <= 6'd0;
            char_x_r  <= 5'd0;
            char_y_r  <= 5'd0;
            count_r   <= 10'd0;
            won_r     <= 1'b0;
            playing_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            dir_r     <= dir_nxt_s;
            tx_r      <= tx_nxt_s;
            ty_r      <= ty_nxt_s;
            char_x_r  <= char_x_nxt_s;
            char_y_r  <= char_y_nxt_s;
            count_r   <= count_nxt_s;
            won_r     <= (state_nxt_s == ST_WON);
            playing_r <= (state_nxt_s == ST_PLAY) || (state_nxt_s == ST_CHECK);
        end
    end

    assign char_x     = {2'b00, char_x_r};
    assign char_y     = {2'b00, char_y_r};
    assign move_count = count_r;
    assign won        = won_r;
    assign playing    = playing_r;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Self-checking bench for maze_player_ctrl with a short debounce time.
// A grid-level reference model tracks position, move count and win state.
module tb_maze_player_ctrl;

    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic         btn_up, btn_down, btn_left, btn_right;
    logic [255:0] path_data;
    logic [4:0]   maze_width, maze_height, start_x, start_y, finish_x, finish_y;
    logic [6:0]   char_x, char_y;
    logic [9:0]   move_count;
    logic         won, playing;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    int m_x, m_y, m_cnt;
    bit m_won, m_play;

    logic [25:0] act_v, exp_v;

    maze_player_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .load(load),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .path_data(path_data), .maze_width(maze_width), .maze_height(maze_height),
        .start_x(start_x), .start_y(start_y), .finish_x(finish_x), .finish_y(finish_y),
        .char_x(char_x), .char_y(char_y), .move_count(move_count), .won(won), .playing(playing)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] dut_vec();
        return {char_x, char_y, move_count, won, playing};
    endfunction

    function automatic logic [25:0] model_vec();
        return {7'(m_x), 7'(m_y), 10'(m_cnt), m_won, m_play};
    endfunction

    function automatic bit tile_open(int x, int y);
        return path_data[x + 16 * y];
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_cnt = 0; m_won = 0; m_play = 0;
    endtask

    task automatic model_load();
        m_x = start_x; m_y = start_y; m_cnt = 0; m_won = 0; m_play = 1;
    endtask

    // mask = {up, down, left, right}; one press yields at most one move
    task automatic model_press(input logic [3:0] mask);
        int dx, dy, nx, ny;
        dx = 0; dy = 0;
        if (mask[3]) dy = -1;
        else if (mask[2]) dy = 1;
        else if (mask[1]) dx = -1;
        else if (mask[0]) dx = 1;
        if (m_play && !m_won && (dx != 0 || dy != 0)) begin
            nx = m_x + dx;
            ny = m_y + dy;
            if (nx >= 0 && ny >= 0 && nx < maze_width && ny < maze_height && tile_open(nx, ny)) begin
                m_x = nx; m_y = ny;
                if (m_cnt < 1023) m_cnt = m_cnt + 1;
                if (nx == finish_x && ny == finish_y) begin
                    m_won = 1; m_play = 0;
                end
            end
        end
    endtask

    task automatic set_buttons(input logic [3:0] mask);
        {btn_up, btn_down, btn_left, btn_right} = mask;
    endtask

    task automatic do_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        model_load();
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        set_buttons(mask);
        repeat (hold) @(negedge clk);
        set_buttons(4'b0000);
        repeat (10) @(negedge clk);
        model_press(mask);
    endtask

    task automatic set_default_maze();
        path_data = '0;
        path_data[0] = 1'b1; path_data[1] = 1'b1; path_data[2] = 1'b1;
        path_data[3] = 1'b1; path_data[16] = 1'b1;
        maze_width = 5'd4; maze_height = 5'd4;
        start_x = 5'd0; start_y = 5'd0; finish_x = 5'd3; finish_y = 5'd0;
    endtask

    task automatic test_reset();
        model_reset();
        act_v = dut_vec(); exp_v = 26'd0;
        n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL reset_initial: got %h expected %h", act_v, exp_v); end
        reset = 1'b1;
        @(negedge clk);
        do_load();
        set_buttons(4'b0001);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_reset();
        act_v = dut_vec(); exp_v = 26'd0;
        n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL reset_midmove: got %h expected %h", act_v, exp_v); end
        reset = 1'b1;
        repeat (20) @(negedge clk);
        model_press(4'b0001);
        act_v = dut_vec(); exp_v = model_vec();
        n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL reset_idle_ignores: got %h expected %h", act_v, exp_v); end
        set_buttons(4'b0000);
        repeat (10) @(negedge clk);
        do_load();
        act_v = dut_vec(); exp_v = model_vec();
        n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL reset_then_load: got %h expected %h", act_v, exp_v); end
    endtask

    task automatic test_single_move();
        do_load();
        set_buttons(4'b0001);
        // 2 sync + DB stable + 1 pulse + 2 FSM edges = 9 edges
        repeat (8) @(negedge clk);
        act_v = dut_vec(); exp_v = model_vec();
        n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL move_too_early: got %h expected %h", act_v, exp_v); end
        @(negedge clk);
        model_press(4'b0001);
        act_v = dut_vec(); exp_v = model_vec();
        n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL move_latency: got %h expected %h", act_v, exp_v); end
        repeat (11) @(negedge clk);
        set_buttons(4'b0000);
        repeat (10) @(negedge clk);
        act_v = dut_vec(); exp_v = {7'd1, 7'd0, 10'd1, 1'b0, 1'b1};
        n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL move_held_once: got %h expected %h", act_v, exp_v); end
    endtask

    task automatic test_walls();
        logic [3:0] seq [4];
        seq = '{4'b1000, 4'b0010, 4'b0100, 4'b0100};
        do_load();
        for (int i = 0; i < 4; i++) begin
            press(seq[i], 8);
            act_v = dut_vec(); exp_v = model_vec();
            n_checks++;
            if (act_v !== exp_v) begin n_fail++; $display("FAIL walls_step%0d: got %h expected %h", i, act_v, exp_v); end
        end
        exp_v = {7'd0, 7'd1, 10'd1, 1'b0, 1'b1};
        n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL walls_final: got %h expected %h", act_v, exp_v); end
    endtask

    task automatic test_priority();
        press(4'b1001, 8);
        act_v = dut_vec(); exp_v = model_vec();
        n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL priority_up_right: got %h expected %h", act_v, exp_v); end
        exp_v = {7'd0, 7'd0, 10'd2, 1'b0, 1'b1};
        n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL priority_abs: got %h expected %h", act_v, exp_v); end
    endtask

    task automatic test_win();
        logic [3:0] seq [6];
        seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100};
        do_load();
        for (int i = 0; i < 6; i++) begin
            press(seq[i], 8);
            act_v = dut_vec(); exp_v = model_vec();
            n_checks++;
            if (act_v !== exp_v) begin n_fail++; $display("FAIL win_step%0d: got %h expected %h", i, act_v, exp_v); end
        end
        exp_v = {7'd3, 7'd0, 10'd3, 1'b1, 1'b0};
        n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL win_final: got %h expected %h", act_v, exp_v); end
    endtask

    task automatic test_load_in_check();
        do_load();
        press(4'b0001, 8);
        set_buttons(4'b0001);
        repeat (8) @(negedge clk);
        act_v = dut_vec(); exp_v = model_vec();
        n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL check_pending: got %h expected %h", act_v, exp_v); end
        do_load();
        act_v = dut_vec(); exp_v = {7'd0, 7'd0, 10'd0, 1'b0, 1'b1};
        n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL load_in_check: got %h expected %h", act_v, exp_v); end
        repeat (6) @(negedge clk);
        set_buttons(4'b0000);
        repeat (10) @(negedge clk);
        act_v = dut_vec(); exp_v = model_vec();
        n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL load_cancels_move: got %h expected %h", act_v, exp_v); end
    endtask

    task automatic test_glitch();
        do_load();
        for (int len = 1; len < DB; len++) begin
            set_buttons(4'b0001);
            repeat (len) @(negedge clk);
            set_buttons(4'b0000);
            repeat (12) @(negedge clk);
            act_v = dut_vec(); exp_v = model_vec();
            n_checks++;
            if (act_v !== exp_v) begin n_fail++; $display("FAIL glitch_len%0d: got %h expected %h", len, act_v, exp_v); end
        end
    endtask

    task automatic test_edges_saturation();
        path_data = '1;
        maze_width = 5'd16; maze_height = 5'd16;
        start_x = 5'd15; start_y = 5'd15; finish_x = 5'd0; finish_y = 5'd0;
        do_load();
        press(4'b0001, 8);
        press(4'b0100, 8);
        act_v = dut_vec(); exp_v = {7'd15, 7'd15, 10'd0, 1'b0, 1'b1};
        n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL edge_right_down: got %h expected %h", act_v, exp_v); end
        for (int i = 0; i < 1030; i++) begin
            press((i % 2 == 0) ? 4'b0010 : 4'b0001, 6);
            if (i == 1021 || i == 1029) begin
                act_v = dut_vec(); exp_v = model_vec();
                n_checks++;
                if (act_v !== exp_v) begin n_fail++; $display("FAIL saturate_i%0d: got %h expected %h", i, act_v, exp_v); end
            end
        end
        exp_v = {7'd15, 7'd15, 10'd1023, 1'b0, 1'b1};
        n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL saturate_abs: got %h expected %h", act_v, exp_v); end
    endtask

    task automatic test_random();
        logic [3:0] mask;
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 8; w++) path_data[w*32 +: 32] = $urandom;
            maze_width  = 5'($urandom_range(1, 16));
            maze_height = 5'($urandom_range(1, 16));
            start_x  = 5'($urandom_range(0, maze_width - 1));
            start_y  = 5'($urandom_range(0, maze_height - 1));
            finish_x = 5'($urandom_range(0, maze_width - 1));
            finish_y = 5'($urandom_range(0, maze_height - 1));
            path_data[start_x + 16 * start_y] = 1'b1;
            @(negedge clk);
            do_load();
            for (int p = 0; p < 25; p++) begin
                if ($urandom_range(0, 11) == 0) do_load();
                if ($urandom_range(0, 3) != 0) mask = 4'(1 << $urandom_range(0, 3));
                else mask = 4'($urandom_range(1, 15));
                press(mask, $urandom_range(6, 12));
                act_v = dut_vec(); exp_v = model_vec();
                n_checks++;
                if (act_v !== exp_v) begin n_fail++; $display("FAIL random_r%0d_p%0d: got %h expected %h", r, p, act_v, exp_v); end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        load  = 1'b0;
        set_buttons(4'b0000);
        set_default_maze();
        repeat (3) @(negedge clk);
        test_reset();
        test_single_move();
        test_walls();
        test_priority();
        test_win();
        test_load_in_check();
        test_glitch();
        test_edges_saturation();
        set_default_maze();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
